// File: rtl/dbg_step_scan_ctrl.sv
// dbg_step_scan_ctrl: debug host controller that single-steps the core with a
// slow step clock and streams a register-file / PC / INSTR snapshot.
module dbg_step_scan_ctrl #(
   parameter int unsigned PULSE_W = 2,
   parameter int unsigned SETTLE  = 1,
   parameter int unsigned NREGS   = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [7:0]  cmd_count,
   input  logic        abort,
   output logic        step_clk,
   output logic [4:0]  reg_sel,
   input  logic [31:0] reg_bus,
   input  logic [31:0] pc,
   input  logic [10:0] instr,
   output logic        snap_valid,
   input  logic        snap_ready,
   output logic [5:0]  snap_idx,
   output logic [31:0] snap_data,
   output logic        done,
   output logic        aborted,
   output logic        busy
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_STEP_HI = 3'd1;
   localparam logic [2:0] S_STEP_LO = 3'd2;
   localparam logic [2:0] S_SEL     = 3'd3;
   localparam logic [2:0] S_WAIT    = 3'd4;
   localparam logic [2:0] S_OUT     = 3'd5;
   localparam logic [2:0] S_FIN     = 3'd6;

   localparam logic [1:0] OP_NOP       = 2'b00;
   localparam logic [1:0] OP_STEP      = 2'b01;
   localparam logic [1:0] OP_SCAN      = 2'b10;
   localparam logic [1:0] OP_STEP_SCAN = 2'b11;

   localparam logic [3:0] PHASE_LAST  = 4'(PULSE_W - 1);
   localparam logic [2:0] SETTLE_LAST = 3'((SETTLE == 0) ? 0 : SETTLE - 1);
   localparam logic [5:0] IDX_LAST    = 6'(NREGS - 1);
   localparam logic [5:0] IDX_PC      = 6'd32;
   localparam logic [5:0] IDX_INSTR   = 6'd33;

   logic [2:0]  state, next_state;
   logic [1:0]  op_r, next_op;
   logic [7:0]  remaining, next_remaining;
   logic [3:0]  phase, next_phase;
   logic [2:0]  settle, next_settle;
   logic [5:0]  idx, next_idx;
   logic        abort_flag, next_abort_flag;
   logic        abort_hit;
   logic [31:0] capture_data;

   // A pending abort is honoured only while a command is actually running.
   assign abort_hit = abort && (state != S_IDLE) && (state != S_FIN);

   // Snapshot payload source for the current index.
   always_comb begin
      capture_data = reg_bus;
      if (idx == IDX_PC) begin
         capture_data = pc;
      end else if (idx == IDX_INSTR) begin
         capture_data = {21'd0, instr};
      end
   end

   // Next-state and next-counter logic.
   always_comb begin
      next_state      = state;
      next_op         = op_r;
      next_remaining  = remaining;
      next_phase      = phase;
      next_settle     = settle;
      next_idx        = idx;
      next_abort_flag = abort_flag;

      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               next_op         = cmd_op;
               next_remaining  = cmd_count;
               next_phase      = 4'd0;
               next_settle     = 3'd0;
               next_idx        = 6'd0;
               next_abort_flag = 1'b0;
               case (cmd_op)
                  OP_NOP:       next_state = S_FIN;
                  OP_STEP:      next_state = (cmd_count != 8'd0) ? S_STEP_HI : S_FIN;
                  OP_SCAN:      next_state = S_SEL;
                  OP_STEP_SCAN: next_state = (cmd_count != 8'd0) ? S_STEP_HI : S_SEL;
                  default:      next_state = S_FIN;
               endcase
            end
         end
         S_STEP_HI: begin
            if (phase == PHASE_LAST) begin
               next_phase = 4'd0;
               next_state = S_STEP_LO;
            end else begin
               next_phase = phase + 4'd1;
            end
         end
         S_STEP_LO: begin
            if (phase == PHASE_LAST) begin
               next_phase     = 4'd0;
               next_remaining = remaining - 8'd1;
               if (remaining <= 8'd1) begin
                  next_state = (op_r == OP_STEP_SCAN) ? S_SEL : S_FIN;
               end else begin
                  next_state = S_STEP_HI;
               end
            end else begin
               next_phase = phase + 4'd1;
            end
         end
         S_SEL: begin
            next_settle = 3'd0;
            // PC and INSTR beats are not behind reg_sel, so no settle time.
            if (idx[5] || (SETTLE == 0)) begin
               next_state = S_OUT;
            end else begin
               next_state = S_WAIT;
            end
         end
         S_WAIT: begin
            if (settle == SETTLE_LAST) begin
               next_state = S_OUT;
            end else begin
               next_settle = settle + 3'd1;
            end
         end
         S_OUT: begin
            if (snap_ready) begin
               if (idx == IDX_INSTR) begin
                  next_state = S_FIN;
               end else begin
                  next_state = S_SEL;
                  if (idx == IDX_PC) begin
                     next_idx = IDX_INSTR;
                  end else if (idx == IDX_LAST) begin
                     next_idx = IDX_PC;
                  end else begin
                     next_idx = idx + 6'd1;
                  end
               end
            end
         end
         S_FIN: begin
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase

      if (abort_hit) begin
         next_state      = S_FIN;
         next_abort_flag = 1'b1;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         op_r       <= OP_NOP;
         remaining  <= 8'd0;
         phase      <= 4'd0;
         settle     <= 3'd0;
         idx        <= 6'd0;
         abort_flag <= 1'b0;
      end else begin
         state      <= next_state;
         op_r       <= next_op;
         remaining  <= next_remaining;
         phase      <= next_phase;
         settle     <= next_settle;
         idx        <= next_idx;
         abort_flag <= next_abort_flag;
      end
   end

   // Registered outputs decoded from the next state so they align with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_clk   <= 1'b0;
         snap_valid <= 1'b0;
         snap_idx   <= 6'd0;
         snap_data  <= 32'd0;
         reg_sel    <= 5'd0;
         done       <= 1'b0;
         aborted    <= 1'b0;
         busy       <= 1'b0;
         cmd_ready  <= 1'b1;
      end else begin
         step_clk   <= (next_state == S_STEP_HI);
         snap_valid <= (next_state == S_OUT);
         busy       <= (next_state != S_IDLE);
         cmd_ready  <= (next_state == S_IDLE);
         done       <= (state == S_FIN);
         aborted    <= (state == S_FIN) && abort_flag;
         if ((next_state == S_SEL) && !next_idx[5]) begin
            reg_sel <= next_idx[4:0];
         end
         if ((next_state == S_OUT) && (state != S_OUT)) begin
            snap_idx  <= idx;
            snap_data <= capture_data;
         end
      end
   end

endmodule

// File: tb/tb_dbg_step_scan_ctrl.sv
// tb_dbg_step_scan_ctrl: scoreboard bench for the step/scan debug controller.
module tb_dbg_step_scan_ctrl;

   localparam int unsigned PULSE_W = 2;
   localparam int unsigned SETTLE  = 1;
   localparam int unsigned NREGS   = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_count;
   logic        abort;
   logic        step_clk;
   logic [4:0]  reg_sel;
   logic [31:0] reg_bus;
   logic [31:0] pc;
   logic [10:0] instr;
   logic        snap_valid;
   logic        snap_ready;
   logic [5:0]  snap_idx;
   logic [31:0] snap_data;
   logic        done;
   logic        aborted;
   logic        busy;

   dbg_step_scan_ctrl #(.PULSE_W(PULSE_W), .SETTLE(SETTLE), .NREGS(NREGS)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_count(cmd_count), .abort(abort), .step_clk(step_clk),
      .reg_sel(reg_sel), .reg_bus(reg_bus), .pc(pc), .instr(instr),
      .snap_valid(snap_valid), .snap_ready(snap_ready), .snap_idx(snap_idx),
      .snap_data(snap_data), .done(done), .aborted(aborted), .busy(busy)
   );

   always #5 clk = ~clk;

   // Register file model: each register holds a recognisable pattern.
   assign reg_bus = 32'hA000_0000 + {27'd0, reg_sel};

   int n_checks = 0;
   int n_fail   = 0;

   logic [37:0] beat_q[$];
   int          pulse_q[$];
   logic        abort_q[$];
   logic [4:0]  exp_reg_sel = 5'd0;
   int          done_cnt = 0;
   int          ready_mode = 0;
   int          stall_cnt = 0;
   int          stall_seen = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: expected pulses, beats and completion for one command.
   task automatic expect_cmd(input logic [1:0] op, input logic [7:0] cnt,
                             input logic [31:0] pcv, input logic [10:0] iv);
      if (op == 2'b01 || op == 2'b11) begin
         for (int k = 0; k < int'(cnt); k++) pulse_q.push_back(int'(PULSE_W));
      end
      if (op == 2'b10 || op == 2'b11) begin
         for (int r = 0; r < int'(NREGS); r++) begin
            beat_q.push_back({6'(r), 32'hA000_0000 + 32'(r)});
         end
         beat_q.push_back({6'd32, pcv});
         beat_q.push_back({6'd33, 21'd0, iv});
         exp_reg_sel = 5'(NREGS - 1);
      end
      abort_q.push_back(1'b0);
   endtask

   // snap_ready driver: tied high, random, stall on idx 5, or held low.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: snap_ready = 1'b1;
         1: snap_ready = ($urandom_range(0, 3) != 0);
         2: begin
            if (snap_valid && snap_idx == 6'd5 && stall_cnt < 10) begin
               snap_ready = 1'b0;
               stall_cnt++;
            end else begin
               snap_ready = 1'b1;
            end
         end
         default: snap_ready = 1'b0;
      endcase
      if (ready_mode != 2) stall_cnt = 0;
   end

   // Monitor: snapshot scoreboard, step-clock shape and completion checks.
   logic        prev_valid, prev_ready, prev_abort, prev_sc, prev_done, have_pulse;
   logic [5:0]  prev_idx;
   logic [31:0] prev_data;
   int          hi_run, lo_run;
   always @(negedge clk) begin
      logic [37:0] e;
      logic        ea;
      if (reset) begin
         prev_valid = 1'b0; prev_ready = 1'b0; prev_abort = 1'b0;
         prev_sc = 1'b0; prev_done = 1'b0; have_pulse = 1'b0;
         hi_run = 0; lo_run = 0;
      end else begin
         if (prev_valid && !prev_ready && !prev_abort) begin
            check("hold_valid", 64'(snap_valid), 64'd1);
            check("hold_idx", 64'(snap_idx), 64'(prev_idx));
            check("hold_data", 64'(snap_data), 64'(prev_data));
         end
         if (prev_valid && prev_ready) check("gap_after_beat", 64'(snap_valid), 64'd0);
         if (snap_valid && !snap_ready && snap_idx == 6'd5) stall_seen++;
         if (snap_valid && snap_ready) begin
            if (beat_q.size() == 0) begin
               check("unexpected_beat_idx", 64'(snap_idx), 64'h3f);
            end else begin
               e = beat_q.pop_front();
               check("beat_idx", 64'(snap_idx), 64'(e[37:32]));
               check("beat_data", 64'(snap_data), 64'(e[31:0]));
            end
         end
         prev_valid = snap_valid; prev_ready = snap_ready; prev_abort = abort;
         prev_idx = snap_idx; prev_data = snap_data;

         if (step_clk) check("step_clk_while_busy", 64'(busy), 64'd1);
         if (step_clk && !prev_sc && have_pulse) check("step_low_width", 64'(lo_run), 64'(PULSE_W));
         if (step_clk) hi_run++;
         if (!step_clk && prev_sc) begin
            if (pulse_q.size() == 0) begin
               check("unexpected_pulse_width", 64'(hi_run), 64'd0);
            end else begin
               check("step_high_width", 64'(hi_run), 64'(pulse_q.pop_front()));
            end
            hi_run = 0; lo_run = 0; have_pulse = 1'b1;
         end
         if (!step_clk) lo_run++;
         prev_sc = step_clk;

         if (done) begin
            ea = (abort_q.size() != 0) ? abort_q.pop_front() : 1'b0;
            check("done_one_cycle", 64'(prev_done), 64'd0);
            check("aborted_flag", 64'(aborted), 64'(ea));
            check("pulses_left", 64'(pulse_q.size()), 64'd0);
            if (!ea) check("beats_left", 64'(beat_q.size()), 64'd0);
            pulse_q.delete();
            beat_q.delete();
            have_pulse = 1'b0;
            done_cnt++;
         end
         prev_done = done;
      end
   end

   task automatic issue(input logic [1:0] op, input logic [7:0] cnt);
      int g = 0;
      cmd_op = op; cmd_count = cnt; cmd_valid = 1'b1;
      while (!cmd_ready && g < 1000) begin
         @(posedge clk); #1; g++;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_op = 2'($urandom_range(0, 3));
      cmd_count = 8'($urandom_range(0, 255));
   endtask

   task automatic wait_done(input int start);
      int g = 0;
      while (done_cnt == start && g < 20000) begin
         @(negedge clk); g++;
      end
      check("done_seen", 64'(done_cnt != start), 64'd1);
      @(posedge clk); #1;
      check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_reg_sel", 64'(reg_sel), 64'(exp_reg_sel));
   endtask

   task automatic check_reset_outputs();
      check("rst_step_clk", 64'(step_clk), 64'd0);
      check("rst_snap_valid", 64'(snap_valid), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_aborted", 64'(aborted), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_reg_sel", 64'(reg_sel), 64'd0);
      check("rst_snap_idx", 64'(snap_idx), 64'd0);
      check("rst_snap_data", 64'(snap_data), 64'd0);
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [7:0] cnt);
      int start;
      pc = $urandom;
      instr = 11'($urandom);
      expect_cmd(op, cnt, pc, instr);
      start = done_cnt;
      issue(op, cnt);
      wait_done(start);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: actual=stuck required=finish");
      $fatal(1, "timeout");
   end

   initial begin
      int start;
      int rises;
      logic psc;
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = 8'd0;
      abort = 1'b0; pc = 32'd0; instr = 11'd0; snap_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      reset = 1'b0;
      check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

      // STEP N=3.
      pc = $urandom; instr = 11'($urandom);
      expect_cmd(2'b01, 8'd3, pc, instr);
      start = done_cnt;
      issue(2'b01, 8'd3);
      check("step_busy", 64'(busy), 64'd1);
      check("step_first_high", 64'(step_clk), 64'd1);
      wait_done(start);

      // NOP: done two cycles after acceptance.
      expect_cmd(2'b00, 8'd0, pc, instr);
      start = done_cnt;
      issue(2'b00, 8'd0);
      check("nop_done_early", 64'(done), 64'd0);
      @(posedge clk); #1;
      check("nop_done_latency", 64'(done), 64'd1);
      wait_done(start);

      // Full scan, no backpressure; then STEP_SCAN with zero steps.
      run_cmd(2'b10, 8'd0);
      run_cmd(2'b11, 8'd0);
      run_cmd(2'b01, 8'd0);

      // Backpressure on idx 5.
      ready_mode = 2;
      stall_seen = 0;
      run_cmd(2'b10, 8'd0);
      check("stall_cycles_idx5", 64'(stall_seen), 64'd10);
      ready_mode = 0;

      // Abort during the second high phase of STEP N=4.
      pulse_q.push_back(int'(PULSE_W));
      pulse_q.push_back(1);
      abort_q.push_back(1'b1);
      start = done_cnt;
      issue(2'b01, 8'd4);
      rises = 0; psc = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (step_clk && !psc) rises++;
         if (rises == 2) break;
         psc = step_clk;
         @(posedge clk); #1;
      end
      check("abort_reached_pulse2", 64'(rises), 64'd2);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_step_low", 64'(step_clk), 64'd0);
      wait_done(start);

      // Random commands with random backpressure.
      ready_mode = 1;
      for (int t = 0; t < 20; t++) begin
         run_cmd(2'($urandom_range(0, 3)), 8'($urandom_range(0, 4)));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      // Reset while a beat is stalled in OUT, then a fresh scan.
      ready_mode = 3;
      expect_cmd(2'b10, 8'd0, pc, instr);
      issue(2'b10, 8'd0);
      for (int c = 0; c < 200 && !snap_valid; c++) begin
         @(posedge clk); #1;
      end
      check("out_reached", 64'(snap_valid), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs();
      beat_q.delete(); pulse_q.delete(); abort_q.delete();
      exp_reg_sel = 5'd0;
      ready_mode = 0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      check("cmd_ready_after_reset2", 64'(cmd_ready), 64'd1);
      run_cmd(2'b10, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dbg_step_scan_ctrl.md
DBG_STEP_SCAN_CTRL -- requirements
Module: dbg_step_scan_ctrl

Interface
REQ-001 SHALL have parameter PULSE_W, default 2: cycles per step-clock phase (high and low), legal range 1..15.
REQ-002 SHALL have parameter SETTLE, default 1: wait cycles between a reg_sel change and reg_bus capture, legal range 0..7.
REQ-003 SHALL have parameter NREGS, default 32: registers scanned, legal range 1..32.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid  in  1  host command strobe.
REQ-007 cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high.
REQ-008 cmd_op  in  2  00 NOP, 01 STEP, 10 SCAN, 11 STEP_SCAN.
REQ-009 cmd_count  in  8  number of steps for STEP and STEP_SCAN.
REQ-010 abort  in  1  cancel the active command.
REQ-011 step_clk  out  1  registered single-step clock to the core.
REQ-012 reg_sel  out  5  register-file read select.
REQ-013 reg_bus  in  32  register-file read data.
REQ-014 pc  in  32  core program counter.
REQ-015 instr  in  11  core instruction field.
REQ-016 snap_valid / snap_ready  out / in  1 / 1  snapshot stream handshake.
REQ-017 snap_idx  out  6  snapshot index: 0..NREGS-1 are registers, 32 is PC, 33 is INSTR.
REQ-018 snap_data  out  32  snapshot payload; INSTR is zero-extended.
REQ-019 done  out  1  one-cycle completion pulse.
REQ-020 aborted  out  1  valid with done; high if the command ended by abort.
REQ-021 busy  out  1  high whenever the state is not IDLE.

Function
REQ-022 SHALL implement these states: IDLE, STEP_HI, STEP_LO, SEL, WAIT, OUT, FIN.
REQ-023 On acceptance in IDLE, SHALL latch cmd_op and cmd_count into internal registers; inputs are ignored after that cycle.
REQ-024 NOP SHALL go IDLE->FIN; done SHALL pulse 2 cycles after acceptance.
REQ-025 STEP with count N>0 SHALL go to STEP_HI. step_clk SHALL be high for exactly PULSE_W cycles, then low in STEP_LO for PULSE_W cycles. The remaining count decrements on leaving STEP_LO, then the block returns to STEP_HI or exits.
REQ-026 STEP or STEP_SCAN with N=0 SHALL issue no step_clk pulse; STEP goes to FIN and STEP_SCAN goes to SEL.
REQ-027 Total step_clk high time SHALL be N*PULSE_W cycles; step_clk SHALL never be high outside STEP_HI.
REQ-028 SCAN, and STEP_SCAN after its steps, SHALL run SEL with index i=0: set reg_sel=i, stay in WAIT for SETTLE cycles, then enter OUT.
REQ-029 On entering OUT, SHALL capture reg_bus into snap_data, set snap_idx=i and assert snap_valid. snap_valid and snap_data SHALL hold stable until snap_ready; backpressure is unbounded.
REQ-030 After a transfer with i<NREGS-1, SHALL increment i and return to SEL. After i=NREGS-1, SHALL emit idx 32 (pc sampled on the OUT entry cycle), then idx 33 (instr), then go to FIN.
REQ-031 snap_valid SHALL drop in the cycle after the transfer; no back-to-back beats, minimum 2 cycles between beats.
REQ-032 FIN SHALL assert done for one cycle and return to IDLE; cmd_ready SHALL be high the following cycle.
REQ-033 abort high in any state other than IDLE and FIN SHALL force step_clk low, snap_valid low and state FIN next cycle, with aborted=1. A pending snapshot beat is dropped.
REQ-034 abort in IDLE SHALL be ignored. abort high in the same cycle as a transfer SHALL count the beat as delivered, then go to FIN with aborted=1.
REQ-035 reg_sel SHALL hold its last value in IDLE.

Reset
REQ-036 While reset is high: state IDLE; step_clk, snap_valid, done, aborted, busy all 0; reg_sel 0; snap_idx 0; snap_data 0; internal counters 0.
REQ-037 cmd_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-038 reset asserted mid-step SHALL drop step_clk asynchronously with no glitch-extended high phase.

Verification
REQ-039 STEP N=3 with PULSE_W=2: step_clk shows 3 pulses, each 2 high / 2 low; done one cycle after the last low phase; aborted=0.
REQ-040 SCAN with NREGS=32, SETTLE=1, reg_bus=0xA000_0000+reg_sel, snap_ready tied 1: 34 beats, idx 0..31 carrying data 0xA000_0000..0xA000_001F, then idx 32=pc, idx 33={21'b0,instr}.
REQ-041 SCAN with snap_ready low for 10 cycles on idx 5: snap_valid, snap_idx=5 and snap_data stable throughout; idx 6 follows after release.
REQ-042 STEP_SCAN N=0: no step_clk pulse; scan output identical to REQ-040.
REQ-043 abort during the second STEP_HI of N=4: step_clk low next cycle; done=1 and aborted=1; no further pulses; cmd_ready returns.
REQ-044 reset pulsed during OUT: all outputs return to the REQ-036 values immediately; a new SCAN then starts at idx 0.
